ac97_frame_tx: RTL and testbench

- AC97 link controller transmit stage. It sits directly upstream of the AD1981B codec and drives its `sync` and `sdata_out` pins.
- Clocked by the codec's `bit_clk` (12.288 MHz). Builds 256-bit frames at 48 kHz.
- Carries one register command (slots 1/2) and one stereo PCM sample (slots 3/4) per frame. Both are taken from valid/ready request ports.
- Codec `reset_b` is generated elsewhere in the system clock domain.

---
 rtl/ac97_frame_tx_pkg.sv | 35 +++
 rtl/ac97_frame_tx_if.sv | 36 +++
 rtl/ac97_frame_rx.sv | 71 +++++++
 rtl/ac97_frame_tx.sv | 168 ++++++++++++++++
 tb/tb_ac97_frame_tx.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ac97_frame_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ac97_pkg
// Description : Shared constants and types for the AC97 link transmit stage
//               and its optional readback parser. Frame geometry, slot
//               start offsets (in transmitted bit order), tag bit indices
//               and the register command record.
// Revision    : 1.0 - initial release
// ============================================================================
package ac97_pkg;

    localparam int FRAME_BITS  = 256;
    localparam int SYNC_BITS   = 16;
    localparam int SLOT_BITS   = 20;

    // First transmitted bit of each slot, counted from frame bit 0.
    localparam int SLOT1_START = 16;
    localparam int SLOT2_START = 36;
    localparam int SLOT3_START = 56;
    localparam int SLOT4_START = 76;

    localparam int TAG_VALID   = 15;
    localparam int TAG_SLOT1   = 14;
    localparam int TAG_SLOT2   = 13;
    localparam int TAG_LEFT    = 12;
    localparam int TAG_RIGHT   = 11;

    typedef struct packed {
        logic        read;
        logic [6:0]  addr;
        logic [15:0] data;
    } ac97_cmd_t;

endpackage
`default_nettype wire

// File: rtl/ac97_frame_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : ac97_frame_tx_if
// Description : Request bus into the AC97 transmit stage. Carries the PCM
//               sample handshake (pcm_left/right/valid/ready) and the codec
//               register command handshake (cmd_read/addr/data/valid/ready).
//               master = request producer, slave = ac97_frame_tx.
//               Samples are two's complement; the bus carries raw bits.
// Revision    : 1.0 - initial release
// ============================================================================
interface ac97_frame_tx_if #(
    parameter int PCM_WIDTH = 20
);
    logic [PCM_WIDTH-1:0] pcm_left;
    logic [PCM_WIDTH-1:0] pcm_right;
    logic                 pcm_valid;
    logic                 pcm_ready;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_read;
    logic [6:0]           cmd_addr;
    logic [15:0]          cmd_data;

    modport master (
        output pcm_left, pcm_right, pcm_valid,
        output cmd_valid, cmd_read, cmd_addr, cmd_data,
        input  pcm_ready, cmd_ready
    );

    modport slave (
        input  pcm_left, pcm_right, pcm_valid,
        input  cmd_valid, cmd_read, cmd_addr, cmd_data,
        output pcm_ready, cmd_ready
    );
endinterface
`default_nettype wire

// File: rtl/ac97_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : ac97_frame_rx
// Description : Readback parser for the codec's incoming serial frame.
//               Frame bit k of sdata_in is sampled while count = k+2. After
//               the tag completes, codec_ready follows tag bit 15; after
//               slot 2 completes, a register read return (tag 14 & 13 set)
//               pulses rd_valid for one clk while count = 58.
// Ports       : clk, rst        - bit clock, synchronous active-high reset
//               count           - frame counter from the transmit stage
//               sdata_in        - re-timed codec serial data
//               codec_ready     - tag bit 15 of the last received frame
//               rd_valid/rd_addr/rd_data - read return
// Revision    : 1.0 - initial release
// ============================================================================
module ac97_frame_rx
    import ac97_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  count,
    input  logic        sdata_in,
    output logic        codec_ready,
    output logic        rd_valid,
    output logic [6:0]  rd_addr,
    output logic [15:0] rd_data
);
    // Only tag, slot 1 and slot 2 are ever inspected, so the shifter keeps
    // just the first 56 bits of the frame.
    localparam int         c_rx_bits    = SLOT2_START + SLOT_BITS;
    localparam int         c_last       = c_rx_bits - 1;
    localparam logic [7:0] c_tag_done   = 8'(SYNC_BITS + 1);
    localparam logic [7:0] c_slot2_done = 8'(c_rx_bits + 1);
    // Bit position of each slot's LSB inside the shifter once slot 2 is in.
    localparam int         c_s1_base    = c_last - SLOT1_START - (SLOT_BITS - 1);
    localparam int         c_s2_base    = c_last - SLOT2_START - (SLOT_BITS - 1);
    // Tag bit t is frame bit 15-t; at slot-2 completion it sits here.
    localparam int         c_tag_base   = c_last - (SYNC_BITS - 1);

    logic [c_rx_bits-1:0] r_rx;
    logic [c_rx_bits-1:0] w_rx_next;
    logic                 w_rd_return;

    assign w_rx_next   = {r_rx[c_rx_bits-2:0], sdata_in};
    assign w_rd_return = w_rx_next[c_tag_base + TAG_SLOT1] &
                         w_rx_next[c_tag_base + TAG_SLOT2];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx        <= '0;
            codec_ready <= 1'b0;
            rd_valid    <= 1'b0;
            rd_addr     <= '0;
            rd_data     <= '0;
        end else begin
            r_rx     <= w_rx_next;
            rd_valid <= 1'b0;
            // When frame bit 15 has just been sampled, tag[t] sits at index t.
            if (count == c_tag_done) begin
                codec_ready <= w_rx_next[TAG_VALID];
            end
            if (count == c_slot2_done && w_rd_return) begin
                rd_valid <= 1'b1;
                rd_addr  <= w_rx_next[c_s1_base + 18 -: 7];
                rd_data  <= w_rx_next[c_s2_base + 19 -: 16];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ac97_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : ac97_frame_tx
// Description : AC97 link transmit stage, clocked by the codec bit clock.
//               Emits a 256-bit frame every 256 clks carrying one register
//               command (slots 1/2) and one stereo PCM sample (slots 3/4),
//               each taken from a one-entry holding register.
// Parameters  : PCM_WIDTH (1..20) - sample width, left-justified in the slot
// Options     : AC97_READBACK_EN  - adds the readback parser and the
//                                   codec_ready/rd_valid/rd_addr/rd_data
//                                   outputs; otherwise sdata_in is ignored
// Ports       : clk, rst     - bit clock, synchronous active-high reset
//               sync         - AC97 SYNC (registered, high for count 0..15)
//               sdata_out    - serial frame data, MSB first, registered
//               sdata_in     - re-timed codec serial data
//               frame_start  - one-clk pulse while count = 0
//               bus          - PCM and command request handshakes
// Revision    : 1.0 - initial release
// ============================================================================
module ac97_frame_tx
    import ac97_pkg::*;
#(
    parameter int PCM_WIDTH = 20
) (
    input  logic                clk,
    input  logic                rst,
    output logic                sync,
    output logic                sdata_out,
    input  logic                sdata_in,
    output logic                frame_start,
    ac97_frame_tx_if.slave      bus
`ifdef AC97_READBACK_EN
    ,
    output logic                codec_ready,
    output logic                rd_valid,
    output logic [6:0]          rd_addr,
    output logic [15:0]         rd_data
`endif
);
    logic [7:0]            r_count;
    logic [7:0]            w_count_next;
    logic                  w_latch;

    logic                  r_pcm_full;
    logic [PCM_WIDTH-1:0]  r_pcm_left;
    logic [PCM_WIDTH-1:0]  r_pcm_right;
    logic                  r_cmd_full;
    ac97_cmd_t             r_cmd;

    logic                  w_pcm_accept;
    logic                  w_cmd_accept;

    logic [15:0]           w_tag;
    logic [SLOT_BITS-1:0]  w_slot1;
    logic [SLOT_BITS-1:0]  w_slot2;
    logic [SLOT_BITS-1:0]  w_slot3;
    logic [SLOT_BITS-1:0]  w_slot4;
    logic [FRAME_BITS-1:0] w_frame;
    logic [FRAME_BITS-1:0] r_shift;

    assign w_count_next = r_count + 8'd1;
    // The edge that takes count 255 -> 0 loads the next frame.
    assign w_latch      = (r_count == 8'hFF);

    assign bus.pcm_ready = ~r_pcm_full;
    assign bus.cmd_ready = ~r_cmd_full;
    assign w_pcm_accept  = bus.pcm_valid & ~r_pcm_full;
    assign w_cmd_accept  = bus.cmd_valid & ~r_cmd_full;

    // Frame assembly from the holds as they stand before the latch edge.
    // Frame bit k lives at w_frame[FRAME_BITS-1-k] so the shifter emits MSB first.
    always_comb begin
        w_tag            = '0;
        w_tag[TAG_SLOT1] = r_cmd_full;
        w_tag[TAG_SLOT2] = r_cmd_full & ~r_cmd.read;
        w_tag[TAG_LEFT]  = r_pcm_full;
        w_tag[TAG_RIGHT] = r_pcm_full;
        w_tag[TAG_VALID] = r_cmd_full | r_pcm_full;

        w_slot1 = '0;
        w_slot2 = '0;
        w_slot3 = '0;
        w_slot4 = '0;
        if (r_cmd_full) begin
            w_slot1 = {r_cmd.read, r_cmd.addr, 12'h000};
            if (!r_cmd.read) begin
                w_slot2 = {r_cmd.data, 4'h0};
            end
        end
        if (r_pcm_full) begin
            // Shifting instead of concatenating keeps PCM_WIDTH = 20 legal.
            w_slot3 = SLOT_BITS'(r_pcm_left)  << (SLOT_BITS - PCM_WIDTH);
            w_slot4 = SLOT_BITS'(r_pcm_right) << (SLOT_BITS - PCM_WIDTH);
        end

        w_frame = '0;
        w_frame[FRAME_BITS-1 -: SYNC_BITS]               = w_tag;
        w_frame[FRAME_BITS-1-SLOT1_START -: SLOT_BITS]   = w_slot1;
        w_frame[FRAME_BITS-1-SLOT2_START -: SLOT_BITS]   = w_slot2;
        w_frame[FRAME_BITS-1-SLOT3_START -: SLOT_BITS]   = w_slot3;
        w_frame[FRAME_BITS-1-SLOT4_START -: SLOT_BITS]   = w_slot4;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= 8'hFF;
            sync        <= 1'b0;
            sdata_out   <= 1'b0;
            frame_start <= 1'b0;
            r_shift     <= '0;
            r_pcm_full  <= 1'b0;
            r_pcm_left  <= '0;
            r_pcm_right <= '0;
            r_cmd_full  <= 1'b0;
            r_cmd       <= '0;
        end else begin
            r_count     <= w_count_next;
            sync        <= (w_count_next < 8'(SYNC_BITS));
            frame_start <= w_latch;

            // sdata_out trails sync by one clk: 0 at count 0, bit n-1 at count n.
            if (w_latch) begin
                r_shift   <= w_frame;
                sdata_out <= 1'b0;
            end else begin
                sdata_out <= r_shift[FRAME_BITS-1];
                r_shift   <= {r_shift[FRAME_BITS-2:0], 1'b0};
            end

            // A push on the latch edge refills the hold for the next frame.
            if (w_pcm_accept) begin
                r_pcm_full  <= 1'b1;
                r_pcm_left  <= bus.pcm_left;
                r_pcm_right <= bus.pcm_right;
            end else if (w_latch) begin
                r_pcm_full  <= 1'b0;
                r_pcm_left  <= '0;
                r_pcm_right <= '0;
            end

            if (w_cmd_accept) begin
                r_cmd_full <= 1'b1;
                r_cmd      <= '{read: bus.cmd_read, addr: bus.cmd_addr, data: bus.cmd_data};
            end else if (w_latch) begin
                r_cmd_full <= 1'b0;
                r_cmd      <= '0;
            end
        end
    end

`ifdef AC97_READBACK_EN
    ac97_frame_rx u_rx (
        .clk         (clk),
        .rst         (rst),
        .count       (r_count),
        .sdata_in    (sdata_in),
        .codec_ready (codec_ready),
        .rd_valid    (rd_valid),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );
`else
    logic w_unused_sdata_in;
    assign w_unused_sdata_in = sdata_in;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ac97_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ac97_frame_tx
// Description : Directed self-checking bench for ac97_frame_tx built with
//               PCM_WIDTH = 16. Frames are captured bit by bit from
//               sdata_out and decoded into tag and slot fields.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ac97_frame_tx;
    localparam int PCM_WIDTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sdata_in = 1'b0;
    logic sync, sdata_out, frame_start;
`ifdef AC97_READBACK_EN
    logic        codec_ready, rd_valid;
    logic [6:0]  rd_addr;
    logic [15:0] rd_data;
`endif

    ac97_frame_tx_if #(.PCM_WIDTH(PCM_WIDTH)) bus ();

    ac97_frame_tx #(.PCM_WIDTH(PCM_WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .sync        (sync),
        .sdata_out   (sdata_out),
        .sdata_in    (sdata_in),
        .frame_start (frame_start),
        .bus         (bus)
`ifdef AC97_READBACK_EN
        ,
        .codec_ready (codec_ready),
        .rd_valid    (rd_valid),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [255:0] cap;      // cap[k] = frame bit k
    logic [255:0] rx_resp;  // codec response frame, rx_resp[k] = frame bit k
    logic         sd0;
    int           sync_hi;
    int           rdv_cnt, rdv_n;
    logic [6:0]   rdv_addr;
    logic [15:0]  rdv_data;

    function automatic logic [15:0] tag_of(input logic [255:0] f);
        logic [15:0] t;
        for (int i = 0; i < 16; i++) t[15-i] = f[i];
        return t;
    endfunction

    function automatic logic [19:0] slot_of(input logic [255:0] f, input int start);
        logic [19:0] s;
        for (int i = 0; i < 20; i++) s[19-i] = f[start+i];
        return s;
    endfunction

    function automatic logic [255:0] make_frame(input logic [15:0] tag,
                                                 input logic [19:0] s1,
                                                 input logic [19:0] s2);
        logic [255:0] f;
        f = '0;
        for (int i = 0; i < 16; i++) f[i] = tag[15-i];
        for (int i = 0; i < 20; i++) begin
            f[16+i] = s1[19-i];
            f[36+i] = s2[19-i];
        end
        return f;
    endfunction

    // Advance to the next negedge with frame_start high (bounded).
    task automatic wait_frame();
        int i;
        i = 0;
        @(negedge clk);
        while (frame_start !== 1'b1 && i < 300) begin
            @(negedge clk);
            i++;
        end
        n_checks++;
        if (frame_start !== 1'b1) $display("FAIL wait_frame: frame_start=%b after %0d clks, want 1", frame_start, i);
        else n_pass++;
    endtask

    // Called on the count-0 negedge; ends on the count-255 negedge.
    task automatic capture();
        cap      = '0;
        sdata_in = 1'b0;
        sd0      = sdata_out;
        sync_hi  = (sync === 1'b1) ? 1 : 0;
        rdv_cnt  = 0;
        rdv_n    = -1;
        rdv_addr = '0;
        rdv_data = '0;
        for (int n = 1; n < 256; n++) begin
            @(negedge clk);
            sdata_in = (n >= 2) ? rx_resp[n-2] : 1'b0;
            cap[n-1] = sdata_out;
            if (sync === 1'b1) sync_hi++;
`ifdef AC97_READBACK_EN
            if (rd_valid === 1'b1) begin
                rdv_cnt++;
                rdv_n    = n;
                rdv_addr = rd_addr;
                rdv_data = rd_data;
            end
`endif
        end
        sdata_in = 1'b0;
    endtask

    // Starts on a negedge; returns on the negedge after the accepting edge.
    task automatic push_cmd(input logic rd, input logic [6:0] addr, input logic [15:0] data);
        int i;
        bus.cmd_valid = 1'b1;
        bus.cmd_read  = rd;
        bus.cmd_addr  = addr;
        bus.cmd_data  = data;
        i = 0;
        while (bus.cmd_ready !== 1'b1 && i < 300) begin
            @(negedge clk);
            i++;
        end
        if (i >= 300) begin
            n_checks++;
            $display("FAIL push_cmd: cmd_ready=%b never high, want 1", bus.cmd_ready);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.pcm_valid = 1'b0; bus.pcm_left = '0; bus.pcm_right = '0;
        bus.cmd_valid = 1'b0; bus.cmd_read = 1'b0; bus.cmd_addr = '0; bus.cmd_data = '0;
        rx_resp = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks += 5;
        if (sync !== 1'b0) $display("FAIL reset_sync: got %b want 0", sync); else n_pass++;
        if (sdata_out !== 1'b0) $display("FAIL reset_sdata: got %b want 0", sdata_out); else n_pass++;
        if (frame_start !== 1'b0) $display("FAIL reset_fs: got %b want 0", frame_start); else n_pass++;
        if (bus.pcm_ready !== 1'b1) $display("FAIL reset_pcm_ready: got %b want 1", bus.pcm_ready); else n_pass++;
        if (bus.cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks += 2;
        if (sync !== 1'b1) $display("FAIL first_sync: got %b want 1", sync); else n_pass++;
        if (frame_start !== 1'b1) $display("FAIL first_fs: got %b want 1", frame_start); else n_pass++;
        capture();
        n_checks += 4;
        if (sd0 !== 1'b0) $display("FAIL idle_sd0: got %b want 0", sd0); else n_pass++;
        if (sync_hi != 16) $display("FAIL sync_width: got %0d want 16", sync_hi); else n_pass++;
        if (cap !== '0) $display("FAIL idle_frame: got %h want 0", cap); else n_pass++;
        @(negedge clk);
        if (frame_start !== 1'b1) $display("FAIL frame_period: fs=%b want 1 at 256 clks", frame_start); else n_pass++;
    endtask

    task automatic test_write_cmd(input logic [6:0] addr, input logic [15:0] data,
                                  input logic [19:0] exp_s1, input logic [19:0] exp_s2);
        wait_frame();
        push_cmd(1'b0, addr, data);
        n_checks++;
        if (bus.cmd_ready !== 1'b0) $display("FAIL wr_ready_low: got %b want 0", bus.cmd_ready); else n_pass++;
        wait_frame();
        n_checks++;
        if (bus.cmd_ready !== 1'b1) $display("FAIL wr_ready_rel: got %b want 1", bus.cmd_ready); else n_pass++;
        capture();
        n_checks += 4;
        if (tag_of(cap) !== 16'hE000) $display("FAIL wr_tag: got %h want e000", tag_of(cap)); else n_pass++;
        if (slot_of(cap, 16) !== exp_s1) $display("FAIL wr_slot1: got %h want %h", slot_of(cap, 16), exp_s1); else n_pass++;
        if (slot_of(cap, 36) !== exp_s2) $display("FAIL wr_slot2: got %h want %h", slot_of(cap, 36), exp_s2); else n_pass++;
        if (cap[254:56] !== '0) $display("FAIL wr_tail: got %h want 0", cap[254:56]); else n_pass++;
    endtask

    task automatic test_read_cmd();
        wait_frame();
        push_cmd(1'b1, 7'h7C, 16'hFFFF);
        wait_frame();
        rx_resp = make_frame(16'hE000, {1'b1, 7'h7C, 12'h000}, {16'h4E53, 4'h0});
        capture();
        rx_resp = '0;
        n_checks += 3;
        if (tag_of(cap) !== 16'hC000) $display("FAIL rd_tag: got %h want c000", tag_of(cap)); else n_pass++;
        if (slot_of(cap, 16) !== 20'hFC000) $display("FAIL rd_slot1: got %h want fc000", slot_of(cap, 16)); else n_pass++;
        if (slot_of(cap, 36) !== 20'h00000) $display("FAIL rd_slot2: got %h want 00000", slot_of(cap, 36)); else n_pass++;
`ifdef AC97_READBACK_EN
        n_checks += 5;
        if (rdv_cnt != 1) $display("FAIL rb_count: got %0d pulses want 1", rdv_cnt); else n_pass++;
        if (rdv_n != 58) $display("FAIL rb_when: got count %0d want 58", rdv_n); else n_pass++;
        if (rdv_addr !== 7'h7C) $display("FAIL rb_addr: got %h want 7c", rdv_addr); else n_pass++;
        if (rdv_data !== 16'h4E53) $display("FAIL rb_data: got %h want 4e53", rdv_data); else n_pass++;
        if (codec_ready !== 1'b1) $display("FAIL rb_codec_ready: got %b want 1", codec_ready); else n_pass++;
`endif
    endtask

    task automatic test_pcm_backpressure();
        wait_frame();
        bus.pcm_valid = 1'b1; bus.pcm_left = 16'h8000; bus.pcm_right = 16'h7FFF;
        @(negedge clk);
        // Second sample offered while the hold is full must be refused.
        bus.pcm_left = 16'h1234; bus.pcm_right = 16'h5678;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.pcm_ready !== 1'b0) $display("FAIL pcm_full_ready: got %b want 0", bus.pcm_ready); else n_pass++;
        bus.pcm_valid = 1'b0;
        wait_frame();
        capture();
        n_checks += 4;
        if (tag_of(cap) !== 16'h9800) $display("FAIL pcm_tag: got %h want 9800", tag_of(cap)); else n_pass++;
        if (slot_of(cap, 56) !== 20'h80000) $display("FAIL pcm_slot3: got %h want 80000", slot_of(cap, 56)); else n_pass++;
        if (slot_of(cap, 76) !== 20'h7FFF0) $display("FAIL pcm_slot4: got %h want 7fff0", slot_of(cap, 76)); else n_pass++;
        if (slot_of(cap, 16) !== 20'h0) $display("FAIL pcm_slot1: got %h want 0", slot_of(cap, 16)); else n_pass++;
    endtask

    // Push lands on the 255 -> 0 edge: absent from this frame, present in the next.
    task automatic test_back_to_back();
        n_checks++;
        if (bus.pcm_ready !== 1'b1) $display("FAIL b2b_ready_pre: got %b want 1", bus.pcm_ready); else n_pass++;
        bus.pcm_valid = 1'b1; bus.pcm_left = 16'h0001; bus.pcm_right = 16'hFFFF;
        @(negedge clk);
        bus.pcm_valid = 1'b0;
        n_checks += 2;
        if (frame_start !== 1'b1) $display("FAIL b2b_align: fs=%b want 1", frame_start); else n_pass++;
        if (bus.pcm_ready !== 1'b0) $display("FAIL b2b_ready_post: got %b want 0", bus.pcm_ready); else n_pass++;
        capture();
        n_checks++;
        if (tag_of(cap) !== 16'h0000) $display("FAIL b2b_cur_tag: got %h want 0000", tag_of(cap)); else n_pass++;
        wait_frame();
        capture();
        n_checks += 3;
        if (tag_of(cap) !== 16'h9800) $display("FAIL b2b_next_tag: got %h want 9800", tag_of(cap)); else n_pass++;
        if (slot_of(cap, 56) !== 20'h00010) $display("FAIL b2b_slot3: got %h want 00010", slot_of(cap, 56)); else n_pass++;
        if (slot_of(cap, 76) !== 20'hFFFF0) $display("FAIL b2b_slot4: got %h want ffff0", slot_of(cap, 76)); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        wait_frame();
        push_cmd(1'b0, 7'h26, 16'hABCD);   // accepted at count 1, pending
        repeat (39) @(negedge clk);         // now at count 40
        rst = 1'b1;
        @(negedge clk);
        n_checks += 5;
        if (sync !== 1'b0) $display("FAIL mid_sync: got %b want 0", sync); else n_pass++;
        if (sdata_out !== 1'b0) $display("FAIL mid_sdata: got %b want 0", sdata_out); else n_pass++;
        if (frame_start !== 1'b0) $display("FAIL mid_fs: got %b want 0", frame_start); else n_pass++;
        if (bus.cmd_ready !== 1'b1) $display("FAIL mid_cmd_ready: got %b want 1", bus.cmd_ready); else n_pass++;
        if (bus.pcm_ready !== 1'b1) $display("FAIL mid_pcm_ready: got %b want 1", bus.pcm_ready); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks += 2;
        if (frame_start !== 1'b1) $display("FAIL mid_restart_fs: got %b want 1", frame_start); else n_pass++;
        if (sync !== 1'b1) $display("FAIL mid_restart_sync: got %b want 1", sync); else n_pass++;
        capture();
        n_checks++;
        if (cap !== '0) $display("FAIL mid_abandon: got tag %h want empty frame", tag_of(cap)); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write_cmd(7'h02, 16'h0000, 20'h02000, 20'h00000);
        test_write_cmd(7'h18, 16'h0808, 20'h18000, 20'h08080);
        test_read_cmd();
        test_pcm_backpressure();
        test_back_to_back();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
